sid_cmd_decoder: RTL and testbench

SID_CMD_DECODER -- requirements
Module: sid_cmd_decoder

---
 rtl/sid_dec_pkg.sv | 15 +
 rtl/sid_resp_slot.sv | 45 ++++
 rtl/sid_cmd_decoder.sv | 98 +++++++++
 tb/tb_sid_cmd_decoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_dec_pkg.sv
// Shared constants and parser state type for the SID command decoder.
package sid_dec_pkg;

  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } parseState_t;

endpackage

// File: rtl/sid_resp_slot.sv
// One-entry response holding register with a guarded transmit handshake.
module sid_resp_slot
  import sid_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  input  logic [7:0] reqByte,
  input  logic       txBusy,
  output logic       txStart,
  output logic [7:0] txData,
  output logic       respOvf
);

  logic       full;
  logic       guard;
  logic [7:0] holdByte;

  // The guard cycle covers the transmitter's latency in raising txBusy.
  assign txStart = full && !txBusy && !guard;
  assign txData  = holdByte;

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      guard    <= 1'b0;
      holdByte <= 8'h00;
      respOvf  <= 1'b0;
    end else begin
      guard   <= txStart;
      respOvf <= 1'b0;
      if (reqValid) begin
        if (full && !txStart) begin
          respOvf <= 1'b1;
        end else begin
          holdByte <= reqByte;
          full     <= 1'b1;
        end
      end else if (txStart) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sid_cmd_decoder.sv
// SID register-write frame decoder; define SID_DEC_ACK_EN to enable ACK/NAK responses.
//
// state | meaning
// HUNT  | waiting for the sync byte
// ADDR  | next byte is the register address
// DATA  | next byte is the write data
// CSUM  | next byte is the checksum (addr ^ data)
module sid_cmd_decoder
  import sid_dec_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
  parameter int         ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_idle,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              sid_we,
  output logic [ADDR_W-1:0] sid_addr,
  output logic [7:0]        sid_data,
  output logic              frame_err,
  output logic              resp_ovf
);

  parseState_t state;
  logic [7:0]  addrReg;
  logic [7:0]  dataReg;
  logic        frameOk;

  assign frameOk = (rx_data == (addrReg ^ dataReg)) && ((addrReg >> ADDR_W) == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      addrReg   <= 8'h00;
      dataReg   <= 8'h00;
      sid_we    <= 1'b0;
      sid_addr  <= '0;
      sid_data  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      sid_we    <= 1'b0;
      frame_err <= 1'b0;
      if (rx_data_ready) begin
        unique case (state)
          HUNT: if (rx_data == SYNC_BYTE) state <= ADDR;
          ADDR: begin
            addrReg <= rx_data;
            state   <= DATA;
          end
          DATA: begin
            dataReg <= rx_data;
            state   <= CSUM;
          end
          CSUM: begin
            state <= HUNT;
            if (frameOk) begin
              sid_we   <= 1'b1;
              sid_addr <= addrReg[ADDR_W-1:0];
              sid_data <= dataReg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (rx_idle && state != HUNT) begin
        state     <= HUNT;
        frame_err <= 1'b1;
      end
    end
  end

`ifdef SID_DEC_ACK_EN
  // Every accept or reject strobe is exactly one response request.
  sid_resp_slot u_respSlot (
    .clk     (clk),
    .rst     (rst),
    .reqValid(sid_we | frame_err),
    .reqByte (sid_we ? ACK_BYTE : NAK_BYTE),
    .txBusy  (tx_busy),
    .txStart (tx_start),
    .txData  (tx_data),
    .respOvf (resp_ovf)
  );
`else
  logic unusedTxBusy;
  assign unusedTxBusy = tx_busy;
  assign tx_start     = 1'b0;
  assign tx_data      = 8'h00;
  assign resp_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_sid_cmd_decoder.sv
// Scoreboard bench for sid_cmd_decoder: directed frames plus randomized frame stream.
module tb_sid_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_idle = 1'b0;
  logic       holdBusy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       sid_we;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       frame_err;
  logic       resp_ovf;

  int busyCnt = 0;
  bit busySt;
  assign tx_busy = holdBusy | (busyCnt != 0);

  sid_cmd_decoder #(.SYNC_BYTE(8'hA5), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_idle(rx_idle), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .frame_err(frame_err), .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         acc;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } outcome_t;

  outcome_t   outQ[$];
  logic [7:0] txQ[$];
  logic [7:0] fb[$];
  int checks = 0, errors = 0, expOvf = 0, ovfSeen = 0;
  bit dropResp = 1'b0, monEn = 1'b0;
  logic [7:0] lastAddr = 8'h00, lastData = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void queueResp(input bit acc);
    if (dropResp) expOvf++;
    else txQ.push_back(acc ? 8'h06 : 8'h15);
  endfunction

  // Reference model: collect frame bytes, judge a frame once four are present.
  function automatic void modelByte(input logic [7:0] b, input int c);
    outcome_t o;
    if (fb.size() == 0) begin
      if (b == 8'hA5) fb.push_back(b);
    end else begin
      fb.push_back(b);
      if (fb.size() == 4) begin
        o.acc  = (fb[3] == (fb[1] ^ fb[2])) && (fb[1] < 8'd32);
        o.addr = o.acc ? fb[1] : 8'h00;
        o.data = o.acc ? fb[2] : 8'h00;
        o.cyc  = c + 1;
        outQ.push_back(o);
        queueResp(o.acc);
        fb.delete();
      end
    end
  endfunction

  function automatic void modelIdle(input int c);
    outcome_t o;
    if (fb.size() != 0) begin
      o.acc = 1'b0; o.addr = 8'h00; o.data = 8'h00; o.cyc = c + 1;
      outQ.push_back(o);
      queueResp(1'b0);
      fb.delete();
    end
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit withIdle, input int gap);
    @(negedge clk);
    rx_data = b; rx_data_ready = 1'b1; rx_idle = withIdle;
    modelByte(b, cyc);
    @(negedge clk);
    rx_data_ready = 1'b0; rx_idle = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    rx_idle = 1'b1;
    modelIdle(cyc);
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rx_idle = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] cs, input int tail);
    sendByte(8'hA5, 1'b0, 0);
    sendByte(a, 1'b0, 0);
    sendByte(d, 1'b0, 0);
    sendByte(cs, 1'b0, 0);
    repeat (tail) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; rx_data_ready = 1'b0; rx_idle = 1'b0;
    @(posedge clk);
    #1;
    fb.delete(); txQ.delete();
    lastAddr = 8'h00; lastData = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Transmitter stand-in: busy for three cycles, rising one cycle after tx_start.
  initial begin
    forever begin
      @(negedge clk);
      busySt = tx_start;
      @(posedge clk);
      #1;
      if (busyCnt > 0) busyCnt--;
      if (busySt) busyCnt = 3;
    end
  end

  initial begin
    outcome_t o;
    wait (monEn);
    forever begin
      @(negedge clk);
      if (sid_we || frame_err) begin
        if (outQ.size() == 0) begin
          check("unexpected_strobe", {30'd0, sid_we, frame_err}, 32'd0);
        end else begin
          o = outQ.pop_front();
          check("strobe_kind", {30'd0, sid_we, frame_err}, o.acc ? 32'd2 : 32'd1);
          check("strobe_cycle", cyc, o.cyc);
          if (o.acc) begin
            lastAddr = o.addr;
            lastData = o.data;
          end
        end
      end
      check("sid_addr_hold", {27'd0, sid_addr}, {24'd0, lastAddr});
      check("sid_data_hold", {24'd0, sid_data}, {24'd0, lastData});
`ifdef SID_DEC_ACK_EN
      if (tx_start) begin
        if (txQ.size() == 0) check("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_data", {24'd0, tx_data}, {24'd0, txQ.pop_front()});
      end
      if (resp_ovf) ovfSeen++;
`else
      check("tx_quiet", {22'd0, tx_start, resp_ovf, tx_data}, 32'd0);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a, d, cs, g;
    int kind, n, ib;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_sid_we", {31'd0, sid_we}, 32'd0);
    check("rst_sid_addr", {27'd0, sid_addr}, 32'd0);
    check("rst_sid_data", {24'd0, sid_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_resp_ovf", {31'd0, resp_ovf}, 32'd0);
    rst = 1'b0;
    monEn = 1'b1;

    sendFrame(8'h03, 8'h7F, 8'h7C, 12);
    sendFrame(8'h03, 8'h7F, 8'h00, 12);
    sendFrame(8'h23, 8'h10, 8'h33, 12);
    sendByte(8'hA5, 1'b0, 0);
    sendByte(8'h01, 1'b0, 0);
    idleCycles(2);
    repeat (12) @(negedge clk);
    sendFrame(8'h01, 8'h02, 8'h03, 12);

    @(posedge clk); #1 holdBusy = 1'b1;
    repeat (2) @(negedge clk);
    sendFrame(8'h04, 8'h11, 8'h15, 0);
    dropResp = 1'b1;
    sendFrame(8'h05, 8'h22, 8'h27, 0);
    sendFrame(8'h06, 8'h33, 8'h35, 0);
    dropResp = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 holdBusy = 1'b0;
    repeat (12) @(negedge clk);

    sendByte(8'hA5, 1'b0, 0);
    sendByte(8'h05, 1'b0, 0);
    doReset();
    sendByte(8'h05, 1'b0, 0);
    sendByte(8'h06, 1'b0, 0);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 10);
      a = 8'($urandom_range(0, 31));
      d = 8'($urandom_range(0, 255));
      cs = a ^ d;
      case (kind)
        4: cs = cs ^ 8'($urandom_range(1, 255));
        5: begin a = 8'($urandom_range(32, 255)); cs = a ^ d; end
        default: ;
      endcase
      if (kind <= 5) begin
        sendByte(8'hA5, 1'b0, $urandom_range(0, 2));
        sendByte(a, 1'b0, $urandom_range(0, 2));
        sendByte(d, 1'b0, $urandom_range(0, 2));
        sendByte(cs, 1'b0, 0);
      end else if (kind == 6) begin
        n = $urandom_range(1, 3);
        sendByte(8'hA5, 1'b0, $urandom_range(0, 2));
        if (n > 1) sendByte(a, 1'b0, $urandom_range(0, 2));
        if (n > 2) sendByte(d, 1'b0, $urandom_range(0, 2));
        idleCycles($urandom_range(1, 3));
      end else if (kind == 7) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        sendByte(g, 1'b0, 0);
      end else if (kind == 8) begin
        idleCycles($urandom_range(1, 4));
      end else if (kind == 9) begin
        ib = $urandom_range(0, 3);
        sendByte(8'hA5, ib == 0, $urandom_range(0, 2));
        sendByte(a, ib == 1, $urandom_range(0, 2));
        sendByte(d, ib == 2, $urandom_range(0, 2));
        sendByte(cs, ib == 3, 0);
      end else begin
        sendByte(8'hA5, 1'b0, 0);
        sendByte(a, 1'b0, 0);
        doReset();
      end
      repeat (10) @(negedge clk);
    end

    for (int w = 0; w < 100; w++) begin
`ifdef SID_DEC_ACK_EN
      if (outQ.size() == 0 && txQ.size() == 0) break;
`else
      if (outQ.size() == 0) break;
`endif
      @(negedge clk);
    end
    check("outcome_drain", outQ.size(), 32'd0);
`ifdef SID_DEC_ACK_EN
    check("tx_drain", txQ.size(), 32'd0);
    check("ovf_count", ovfSeen, expOvf);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
